mem_arbiter: RTL

- Shares the single-port data/instruction memory between the IFU (fetch) and the LSU (lw/lbu/sw/sb issued from decoded mem_valid/mem_wen/mem_addr/mem_wmask).
- Sits between both requesters and the memory interface.
- Arbitrates, registers the granted request and sequences one outstanding transaction through a 3-state FSM.
- Routes the response back to its owner.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration), used by
// mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Owner encoding of the in-flight transaction
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant logic for the memory arbiter.
// Grants are only ever raised while the sequencer is idle; they double as the
// ready outputs toward the requesters.
// Macro MEM_ARB_RR_EN: when defined, round-robin between IFU and LSU using
// last_owner; when undefined, fixed LSU-over-IFU priority (last_owner unused).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic idle,
    input  logic last_owner,
    output logic grant_ifu,
    output logic grant_lsu
);

`ifdef MEM_ARB_RR_EN
    // On contention the requester that did not win last time is granted;
    // a lone requester is always granted.
    always_comb begin
        grant_ifu = idle & (~lsu_valid | (ifu_valid & (last_owner == OWNER_LSU)));
        grant_lsu = idle & (~ifu_valid | (lsu_valid & (last_owner == OWNER_IFU)));
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // LSU always wins; IFU is held off whenever the LSU is requesting.
    always_comb begin
        grant_lsu = idle;
        grant_ifu = idle & ~lsu_valid;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IFU and the LSU.
// Registers the granted request, runs one transaction at a time through
// IDLE -> REQ -> RESP and routes the response to its owner combinationally.
// Macro MEM_ARB_RR_EN: round-robin arbitration with a last_owner register;
// default build uses fixed LSU-over-IFU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic idle;
    logic last_owner;
    logic grant_ifu, grant_lsu;
    logic acc_ifu, acc_lsu;
    logic resp_hit;

    assign idle = (state_q == ST_IDLE);

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .idle       (idle),
        .last_owner (last_owner),
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign acc_ifu       = ifu_req_valid & grant_ifu;
    assign acc_lsu       = lsu_req_valid & grant_lsu;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // Remember who won the most recent accept for the next contention.
    always_comb begin
        last_owner_d = last_owner_q;
        if (acc_lsu) begin
            last_owner_d = OWNER_LSU;
        end else if (acc_ifu) begin
            last_owner_d = OWNER_IFU;
        end
    end

    // last_owner register, cleared to IFU on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWNER_IFU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWNER_IFU;
`endif

    // Next-state and payload capture; payload only changes on an accept.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_lsu) begin
                    state_d = ST_REQ;
                    owner_d = OWNER_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wen ? lsu_wmask : '0;
                end else if (acc_ifu) begin
                    state_d = ST_REQ;
                    owner_d = OWNER_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and payload registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Memory side and status outputs.
    always_comb begin
        mem_req_valid = (state_q == ST_REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        busy          = ~idle;
    end

    // Route the response to its owner; memory responses outside RESP are dropped.
    always_comb begin
        resp_hit       = (state_q == ST_RESP) & mem_resp_valid;
        ifu_resp_valid = resp_hit & (owner_q == OWNER_IFU);
        lsu_resp_valid = resp_hit & (owner_q == OWNER_LSU);
        ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
        lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
    end

endmodule
